// File: rtl/cic_rate_controller.sv
// Sequences run-time decimation-rate changes into the downsampler / CIC chain, aligning to frame
// boundaries and blanking settling outputs. Optional alignment timeout: define RATE_TIMEOUT_EN.
module cic_rate_controller #(
  parameter int unsigned DATA_WIDTH_RATE = 16,
  parameter int unsigned FLUSH_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH_RATE-1:0] s_axis_cfg_tdata,
  input  logic                       s_axis_cfg_tvalid,
  output logic                       s_axis_cfg_tready,
  input  logic [FLUSH_WIDTH-1:0]     flush_count,
  input  logic                       ds_out_tvalid,
  output logic [DATA_WIDTH_RATE-1:0] m_axis_rate_tdata,
  output logic                       m_axis_rate_tvalid,
  output logic                       out_enable,
  output logic [DATA_WIDTH_RATE-1:0] rate_current,
  output logic                       busy,
  output logic                       err_rate_zero
);

  typedef enum logic [1:0] {StIdle, StWaitAlign, StApply, StFlush} state_e;

  state_e                     state_q, state_d;
  logic [DATA_WIDTH_RATE-1:0] pending_rate_q, pending_rate_d;
  logic [DATA_WIDTH_RATE-1:0] rate_current_q, rate_current_d;
  logic [FLUSH_WIDTH-1:0]     pending_flush_q, pending_flush_d;
  logic [FLUSH_WIDTH-1:0]     flush_cnt_q, flush_cnt_d;
  logic                       first_done_q, first_done_d;
  logic                       err_q, err_d;
  logic                       cfg_fire;
  logic                       align_go;

  assign cfg_fire = s_axis_cfg_tvalid && s_axis_cfg_tready;

`ifdef RATE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            enter_wait;

  assign enter_wait = (state_q == StIdle) && cfg_fire && (s_axis_cfg_tdata != '0) && first_done_q;
  // A boundary and an expired timeout in the same cycle both simply lead to APPLY.
  assign align_go   = ds_out_tvalid || (tmo_q >= TmoW'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d = tmo_q;
    if (enter_wait) begin
      tmo_d = '0;
    end else if ((state_q == StWaitAlign) && (tmo_q < TmoW'(TIMEOUT_CYCLES))) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign align_go       = ds_out_tvalid;
`endif

  always_comb begin
    state_d         = state_q;
    pending_rate_d  = pending_rate_q;
    pending_flush_d = pending_flush_q;
    rate_current_d  = rate_current_q;
    flush_cnt_d     = flush_cnt_q;
    first_done_d    = first_done_q;
    err_d           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          if (s_axis_cfg_tdata == '0) begin
            err_d = 1'b1;
          end else begin
            pending_rate_d  = s_axis_cfg_tdata;
            pending_flush_d = flush_count;
            // Before the first change there is no frame phase to respect.
            state_d         = first_done_q ? StWaitAlign : StApply;
          end
        end
      end
      StWaitAlign: begin
        if (align_go) state_d = StApply;
      end
      StApply: begin
        rate_current_d = pending_rate_q;
        first_done_d   = 1'b1;
        flush_cnt_d    = pending_flush_q;
        state_d        = (pending_flush_q != '0) ? StFlush : StIdle;
      end
      StFlush: begin
        if (flush_cnt_q == '0) begin
          state_d = StIdle;
        end else if (ds_out_tvalid) begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FLUSH_WIDTH'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      pending_rate_q  <= '0;
      pending_flush_q <= '0;
      rate_current_q  <= '1;
      flush_cnt_q     <= '0;
      first_done_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_rate_q  <= pending_rate_d;
      pending_flush_q <= pending_flush_d;
      rate_current_q  <= rate_current_d;
      flush_cnt_q     <= flush_cnt_d;
      first_done_q    <= first_done_d;
      err_q           <= err_d;
    end
  end

  assign s_axis_cfg_tready  = (state_q == StIdle) && !reset;
  assign m_axis_rate_tvalid = (state_q == StApply);
  assign m_axis_rate_tdata  = (state_q == StApply) ? pending_rate_q : rate_current_q;
  assign out_enable         = (state_q != StFlush);
  assign busy               = (state_q != StIdle);
  assign rate_current       = rate_current_q;
  assign err_rate_zero      = err_q;

endmodule

// File: tb/tb_cic_rate_controller.sv
// Bench for cic_rate_controller: rate strobes are checked against a queue of expected rates,
// timing and gating are checked inline per scenario.
module tb_cic_rate_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [7:0]  flush_count;
  logic        ds_out_tvalid;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        out_enable;
  logic [15:0] rate_current;
  logic        busy;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  cic_rate_controller #(
    .DATA_WIDTH_RATE(16),
    .FLUSH_WIDTH    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_cfg_tdata  (cfg_tdata),
    .s_axis_cfg_tvalid (cfg_tvalid),
    .s_axis_cfg_tready (cfg_tready),
    .flush_count       (flush_count),
    .ds_out_tvalid     (ds_out_tvalid),
    .m_axis_rate_tdata (m_tdata),
    .m_axis_rate_tvalid(m_tvalid),
    .out_enable        (out_enable),
    .rate_current      (rate_current),
    .busy              (busy),
    .err_rate_zero     (err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && m_tvalid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: got tdata=%h, required no strobe", m_tdata);
      end else begin
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if (m_tdata !== exp) begin
          miscompares++;
          $display("FAIL strobe_tdata: got %h, required %h", m_tdata, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (cfg_tready !== 1'b1) begin miscompares++; $display("FAIL rst_tready: got %b, required 1", cfg_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b, required 0", m_tvalid); end
    vectors++; if (m_tdata !== 16'hffff) begin miscompares++; $display("FAIL rst_tdata: got %h, required ffff", m_tdata); end
    vectors++; if (rate_current !== 16'hffff) begin miscompares++; $display("FAIL rst_rate: got %h, required ffff", rate_current); end
    vectors++; if (out_enable !== 1'b1) begin miscompares++; $display("FAIL rst_out_en: got %b, required 1", out_enable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", err); end
  endtask

  task automatic test_first_apply();
    cfg_tdata = 16'd4; flush_count = 8'd2; cfg_tvalid = 1'b1; exp_q.push_back(16'd4);
    tick();
    cfg_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL first_strobe: got %b, required 1", m_tvalid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_busy: got %b, required 1", busy); end
    tick();
    vectors++; if (out_enable !== 1'b0) begin miscompares++; $display("FAIL first_blank0: got %b, required 0", out_enable); end
    vectors++; if (rate_current !== 16'd4) begin miscompares++; $display("FAIL first_rate: got %h, required 0004", rate_current); end
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (out_enable !== 1'b0) begin miscompares++; $display("FAIL first_blank1: got %b, required 0", out_enable); end
    tick();
    ds_out_tvalid = 1'b1;
    vectors++; if (out_enable !== 1'b0) begin miscompares++; $display("FAIL first_blank_hold: got %b, required 0", out_enable); end
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (out_enable !== 1'b1) begin miscompares++; $display("FAIL first_unblank: got %b, required 1", out_enable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL first_idle: got %b, required 0", busy); end
  endtask

  task automatic test_aligned();
    cfg_tdata = 16'd8; flush_count = 8'd0; cfg_tvalid = 1'b1; exp_q.push_back(16'd8);
    tick();
    cfg_tvalid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL align_busy: got %b, required 1", busy); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL align_early: got %b, required 0", m_tvalid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (out_enable !== 1'b1 || busy !== 1'b1) begin
        miscompares++; $display("FAIL align_wait%0d: got oe=%b busy=%b, required 1 1", i, out_enable, busy);
      end
    end
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL align_strobe: got %b, required 1", m_tvalid); end
    vectors++; if (out_enable !== 1'b1) begin miscompares++; $display("FAIL align_oe: got %b, required 1", out_enable); end
    tick();
    vectors++; if (busy !== 1'b0 || out_enable !== 1'b1) begin
      miscompares++; $display("FAIL align_idle: got busy=%b oe=%b, required 0 1", busy, out_enable);
    end
    vectors++; if (rate_current !== 16'd8) begin miscompares++; $display("FAIL align_rate: got %h, required 0008", rate_current); end
  endtask

  task automatic test_rate_zero();
    cfg_tdata = 16'd0; flush_count = 8'd3; cfg_tvalid = 1'b1;
    tick();
    cfg_tvalid = 1'b0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL zero_err: got %b, required 1", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b, required 0", busy); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL zero_strobe: got %b, required 0", m_tvalid); end
    tick();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL zero_pulse: got %b, required 0", err); end
    vectors++; if (rate_current !== 16'd8) begin miscompares++; $display("FAIL zero_rate: got %h, required 0008", rate_current); end
  endtask

  task automatic test_back_to_back();
    cfg_tdata = 16'd5; flush_count = 8'd1; cfg_tvalid = 1'b1; exp_q.push_back(16'd5);
    tick();
    cfg_tdata = 16'd3; flush_count = 8'd0; exp_q.push_back(16'd3);
    vectors++; if (cfg_tready !== 1'b0) begin miscompares++; $display("FAIL b2b_stall0: got %b, required 0", cfg_tready); end
    tick();
    vectors++; if (cfg_tready !== 1'b0) begin miscompares++; $display("FAIL b2b_stall1: got %b, required 0", cfg_tready); end
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b1 || cfg_tready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_apply: got strobe=%b tready=%b, required 1 0", m_tvalid, cfg_tready);
    end
    tick();
    vectors++; if (out_enable !== 1'b0 || cfg_tready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_flush: got oe=%b tready=%b, required 0 0", out_enable, cfg_tready);
    end
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (cfg_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b, required 1", cfg_tready); end
    tick();
    cfg_tvalid = 1'b0;
    vectors++; if (busy !== 1'b1 || rate_current !== 16'd5) begin
      miscompares++; $display("FAIL b2b_accept: got busy=%b rate=%h, required 1 0005", busy, rate_current);
    end
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL b2b_strobe2: got %b, required 1", m_tvalid); end
    tick();
    vectors++; if (rate_current !== 16'd3 || busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_done: got rate=%h busy=%b, required 0003 0", rate_current, busy);
    end
  endtask

  task automatic test_reset_flush();
    cfg_tdata = 16'd7; flush_count = 8'd5; cfg_tvalid = 1'b1; exp_q.push_back(16'd7);
    tick();
    cfg_tvalid = 1'b0;
    ds_out_tvalid = 1'b1;
    tick();
    ds_out_tvalid = 1'b0;
    tick();
    vectors++; if (out_enable !== 1'b0) begin miscompares++; $display("FAIL rf_flush: got %b, required 0", out_enable); end
    reset = 1'b1; cfg_tdata = 16'd9; flush_count = 8'd0; cfg_tvalid = 1'b1;
    tick();
    vectors++; if (out_enable !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rf_idle: got oe=%b busy=%b, required 1 0", out_enable, busy);
    end
    vectors++; if (rate_current !== 16'hffff) begin miscompares++; $display("FAIL rf_rate: got %h, required ffff", rate_current); end
    vectors++; if (cfg_tready !== 1'b0) begin miscompares++; $display("FAIL rf_tready: got %b, required 0", cfg_tready); end
    reset = 1'b0; cfg_tvalid = 1'b0;
    tick();
    vectors++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rf_no_hs: got strobe=%b busy=%b, required 0 0", m_tvalid, busy);
    end
    cfg_tdata = 16'd2; cfg_tvalid = 1'b1; exp_q.push_back(16'd2);
    tick();
    cfg_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL rf_direct: got %b, required 1", m_tvalid); end
    tick();
    vectors++; if (rate_current !== 16'd2 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rf_rate2: got rate=%h busy=%b, required 0002 0", rate_current, busy);
    end
  endtask

  task automatic test_timeout();
    cfg_tdata = 16'd6; flush_count = 8'd0; cfg_tvalid = 1'b1; exp_q.push_back(16'd6);
    tick();
    cfg_tvalid = 1'b0;
`ifdef RATE_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++; if (m_tvalid !== 1'b0) begin
        miscompares++; $display("FAIL tmo_early%0d: got %b, required 0", k, m_tvalid);
      end
    end
    tick();
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL tmo_strobe: got %b, required 1", m_tvalid); end
    tick();
    vectors++; if (rate_current !== 16'd6 || busy !== 1'b0) begin
      miscompares++; $display("FAIL tmo_done: got rate=%h busy=%b, required 0006 0", rate_current, busy);
    end
`else
    begin
      int strobes;
      strobes = 0;
      for (int k = 0; k < 100; k++) begin
        tick();
        if (m_tvalid === 1'b1) strobes++;
      end
      vectors++; if (strobes != 0) begin miscompares++; $display("FAIL notmo_strobes: got %0d, required 0", strobes); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL notmo_busy: got %b, required 1", busy); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL notmo_reset: got %b, required 0", busy); end
`endif
  endtask

  initial begin
    reset = 1'b1; cfg_tdata = '0; cfg_tvalid = 1'b0; flush_count = '0; ds_out_tvalid = 1'b0;
    test_reset();
    test_first_apply();
    test_aligned();
    test_rate_zero();
    test_back_to_back();
    test_reset_flush();
    test_timeout();
    tick();
    vectors++; if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_rate_controller.md
Name: cic_rate_controller

Overview:
- Sequences run-time decimation-rate changes into the variable downsampler / CIC decimator chain.
- Accepts rate requests over an AXI-Stream-style config port. Waits for a decimation frame boundary, then issues a single-cycle rate update to the datapath.
- After the update, blanks a programmable number of settling outputs, so downstream logic never sees partial-frame or transient samples.

Parameters:
- DATA_WIDTH_RATE, 16, width of decimation rate words.
- FLUSH_WIDTH, 8, width of the settling-sample count.
- TIMEOUT_CYCLES, 1024, alignment timeout in clk cycles; used only with RATE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_axis_cfg_tdata  input  DATA_WIDTH_RATE  requested decimation rate (unsigned).
- s_axis_cfg_tvalid  input  1  rate request valid.
- s_axis_cfg_tready  output  1  controller can accept a request.
- flush_count  input  FLUSH_WIDTH  number of datapath outputs to blank after a change; sampled at cfg handshake.
- ds_out_tvalid  input  1  monitored output-valid of the downsampler (frame boundary marker).
- m_axis_rate_tdata  output  DATA_WIDTH_RATE  rate word to the downsampler.
- m_axis_rate_tvalid  output  1  single-cycle rate update strobe to the downsampler.
- out_enable  output  1  downstream gate; 0 = discard datapath output.
- rate_current  output  DATA_WIDTH_RATE  rate most recently applied.
- busy  output  1  change in progress (state != IDLE).
- err_rate_zero  output  1  one-cycle pulse: request with rate 0 rejected.

Behaviour:
- States: IDLE, WAIT_ALIGN, APPLY, FLUSH. All outputs are registered or decoded directly from the state register.
- Reset values:
  - state=IDLE, s_axis_cfg_tready=1, m_axis_rate_tvalid=0, m_axis_rate_tdata=all ones.
  - rate_current=all ones, which matches the downsampler's reset rate.
  - out_enable=1, busy=0, err_rate_zero=0, first_done=0, internal counters=0.
- Handshake: a transfer occurs when s_axis_cfg_tvalid && s_axis_cfg_tready.
  - tready=1 only in IDLE and not during reset.
  - When tready=0, the master holds tvalid/tdata; the request is stalled, never dropped.
- IDLE:
  - Handshake with tdata==0: err_rate_zero=1 next cycle; stay IDLE; nothing latched.
  - Handshake with tdata!=0: latch pending_rate=tdata and pending_flush=flush_count.
    - If first_done=0, go to APPLY.
    - Otherwise go to WAIT_ALIGN.
  - A request equal to rate_current is still applied, since it re-synchronises the counter.
- WAIT_ALIGN:
  - Go to APPLY in the cycle after ds_out_tvalid is sampled 1. That sample is the final sample at the old rate and is passed (out_enable=1).
- APPLY (exactly 1 cycle):
  - m_axis_rate_tvalid=1, m_axis_rate_tdata=pending_rate.
  - rate_current<=pending_rate; first_done<=1; flush counter<=pending_flush.
  - Next state: FLUSH if pending_flush!=0, else IDLE.
  - m_axis_rate_tvalid is 0 in every other state.
- FLUSH:
  - out_enable=0.
  - Each ds_out_tvalid=1 decrements the counter.
  - When the counter==1 and ds_out_tvalid=1, go to IDLE. out_enable returns to 1 in that next cycle.
  - Cycles with no ds_out_tvalid hold the state; there is no timeout in FLUSH.
- out_enable = (state != FLUSH). busy = (state != IDLE).
- Latency:
  - Handshake at T, first_done=1: WAIT_ALIGN at T+1. Boundary sampled at A gives the rate strobe at A+1 and FLUSH at A+2.
  - First request after reset: strobe at T+1.
- Width rules:
  - Rates are unsigned and passed unmodified.
  - The flush counter is FLUSH_WIDTH bits and never wraps below 0.
- Reset mid-operation: any state returns to IDLE next cycle. The pending request is discarded; rate_current=all ones; first_done=0.
- Reset and cfg tvalid asserted together: reset wins; no handshake.

Optional Feature:
- Macro RATE_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to WAIT_ALIGN and increments every cycle.
  - If TIMEOUT_CYCLES cycles elapse with no ds_out_tvalid, go to APPLY anyway.
  - A boundary and the timeout in the same cycle count as a boundary (identical behaviour).
- Undefined: no timeout logic; WAIT_ALIGN waits indefinitely.

Test Plan:
- After reset, request rate=4, flush_count=2 -> strobe with tdata=4 exactly 1 cycle after the handshake. out_enable=0 until the 2nd ds_out_tvalid, 1 on the following cycle. rate_current=4.
- With rate 4 active, request rate=8, flush_count=0; ds_out_tvalid pulses 5 cycles later -> busy=1, strobe 1 cycle after that pulse, back to IDLE directly, out_enable stays 1 throughout.
- Request rate=0 -> err_rate_zero pulses 1 cycle; state stays IDLE; no strobe; rate_current unchanged.
- Second request (rate=3) held valid while busy -> tready=0 until IDLE. It is accepted the first IDLE cycle, then the next strobe carries tdata=3.
- Reset asserted during FLUSH with counter=5 -> next cycle IDLE, out_enable=1, rate_current=0xFFFF. The next request applies with no alignment wait.
- RATE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ds_out_tvalid in WAIT_ALIGN -> strobe issued 17 cycles after WAIT_ALIGN entry. Without the macro -> no strobe for at least 100 cycles.
